// File: rtl/controle_displays_pkg.sv
// Shared types and constants for the display sequencer.
package controle_displays_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} estado_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam int         MAX_VALOR   = 9999;
  localparam int         N_DIGITS    = 4;
endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction step: add 3 to a BCD nibble when it is 5 or more.
module ajuste_bcd (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/controle_displays.sv
// Binary-to-BCD sequencer feeding the four-digit seven-segment decoder.
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module controle_displays
  import controle_displays_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valor,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       milhar,
  output logic [3:0]       centena,
  output logic [3:0]       dezena,
  output logic [3:0]       unidade,
  output logic             ovf,
  output logic             out_valid
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] RST_HI = BLANK_DIGIT;
`else
  localparam logic [3:0] RST_HI = 4'h0;
`endif

  estado_t state, state_next;

  logic [WIDTH-1:0]                sreg;
  logic [15:0]                     acc;
  logic [15:0]                     acc_adj;
  logic [16:0]                     shifted;
  logic [CW-1:0]                   cnt;
  logic                            ovf_pend;
  logic                            last;
  logic [N_DIGITS-1:0][3:0]        dig_new;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_aj
    ajuste_bcd u_aj (.d(acc[4*g +: 4]), .q(acc_adj[4*g +: 4]));
  end

  assign shifted = {acc_adj, sreg[WIDTH-1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONV;
      CONV:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Digits as they will be written on the CONV->DONE edge.
  always_comb begin
    dig_new = shifted[15:0];
    if (ovf_pend) begin
      dig_new = {N_DIGITS{BLANK_DIGIT}};
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_new[3] == 4'h0) dig_new[3] = BLANK_DIGIT;
      if (dig_new[2] == 4'h0 && dig_new[3] == BLANK_DIGIT) dig_new[2] = BLANK_DIGIT;
      if (dig_new[1] == 4'h0 && dig_new[2] == BLANK_DIGIT) dig_new[1] = BLANK_DIGIT;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      milhar   <= RST_HI;
      centena  <= RST_HI;
      dezena   <= RST_HI;
      unidade  <= 4'h0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg     <= valor;
          acc      <= '0;
          cnt      <= '0;
          ovf_pend <= (32'(valor) > 32'(MAX_VALOR));
        end
        CONV: begin
          acc  <= shifted[15:0];
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          // A carry out of the top nibble only happens for values already flagged.
          ovf_pend <= ovf_pend | shifted[16];
          if (last) begin
            milhar  <= dig_new[3];
            centena <= dig_new[2];
            dezena  <= dig_new[1];
            unidade <= dig_new[0];
            ovf     <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/controle_displays.md
# controle_displays

Sequencer in front of the four-digit BCD-to-seven-segment decoder. Accepts a binary value over a valid/ready handshake and converts it to four BCD digits with an iterative shift-and-add-3 (double-dabble) engine, one bit per cycle. Holds the last result on `milhar`/`centena`/`dezena`/`unidade` for the decoder. Handles out-of-range values and, optionally, leading-zero blanking.

## Interface
- `WIDTH`, default 14: input value width; legal range 4..14.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valor`  in  WIDTH  binary value to display; sampled only on handshake.
- `in_valid`  in  1  `valor` is valid.
- `in_ready`  out  1  block can accept a value; high only in IDLE.
- `milhar`, `centena`, `dezena`, `unidade`  out  4 each  BCD digits to the decoder; 4'hF means blank, which the decoder renders as all segments off.
- `ovf`  out  1  last accepted value exceeded 9999.
- `out_valid`  out  1  one-cycle pulse when new digits appear.

## Operation
- States:
  - IDLE: `in_ready=1`. On `in_valid`, go to CONV. Capture `valor` into the shift register. Clear the BCD accumulator and iteration counter. Register `ovf_pend = (valor > 9999)`.
  - CONV: each cycle, apply add-3 to every 4-bit accumulator nibble ≥5. Then shift {accumulator, shift register} left by 1. Increment the counter. After WIDTH iterations, go to DONE, writing outputs on the same edge.
  - DONE: `out_valid=1` for exactly this cycle, then go to IDLE unconditionally.
- Accumulator width is 16 bits (4 nibbles). Values above 9999 are never decoded for display.
- Output write at CONV→DONE:
  - If `ovf_pend`: all four digits = 4'hF and `ovf=1`.
  - Otherwise: digits = accumulator nibbles (MSB nibble→`milhar`) and `ovf=0`.
- Digits and `ovf` hold until the next DONE write or reset.
- `in_valid` outside IDLE is ignored; `valor` need not stay stable after acceptance.
- Reset values:
  - `in_ready=1` (IDLE), `out_valid=0`, `ovf=0`.
  - Digits as given under Configuration (display shows "0").
- Reset mid-conversion: abort immediately, return to IDLE, force reset values. The partial result is discarded and no `out_valid` is emitted.

## Timing
- Handshake at edge t (IDLE, `in_valid=1`). CONV occupies cycles t+1..t+WIDTH. Digits update and `out_valid=1` in cycle t+WIDTH+1 (DONE). `in_ready=1` again in cycle t+WIDTH+2.
- WIDTH=14: 15 cycles handshake→`out_valid`, 16 cycles between back-to-back acceptances.
- With `in_valid` held high continuously, the next value is accepted on the first IDLE edge after DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - At the output write, `milhar`=4'hF if zero.
  - `centena`=4'hF if zero and `milhar` is blanked.
  - `dezena`=4'hF if zero and `centena` is blanked.
  - `unidade` is never blanked.
  - Reset digits: F,F,F,0.
- Undefined: digits are written verbatim; reset digits are 0,0,0,0. The overflow path is identical in both builds.

## Structure
- Package `controle_displays_pkg`:
  - State enum {IDLE, CONV, DONE}.
  - `BLANK_DIGIT=4'hF`, `MAX_VALOR=9999`, `N_DIGITS=4`.
- Sub-module `ajuste_bcd`: combinational add-3-if-≥5 on one nibble, instantiated four times in the CONV datapath.
- Counter width: $clog2(WIDTH+1).

## Test plan
- 1234 accepted, WIDTH=14 → `out_valid` at 15th cycle after handshake; digits 1,2,3,4; `ovf=0`; `in_ready` returns one cycle later.
- 7 → with `LEADING_ZERO_BLANK_EN`: F,F,F,7. Without: 0,0,0,7. 0 → F,F,F,0 / 0,0,0,0. 305 → F,3,0,5 / 0,3,0,5.
- 9999 → 9,9,9,9, `ovf=0`. 10000 and 16383 → F,F,F,F, `ovf=1`. A following 42 clears `ovf` and shows F,F,4,2 / 0,0,4,2.
- `in_valid` held high with values 12 then 34 → second accepted exactly 16 cycles after the first. `in_valid` pulses during CONV/DONE are ignored.
- `reset` asserted at the 7th CONV cycle of 5678 → next cycle IDLE, reset digits, no `out_valid`. Previous result 1111 is not restored.
